cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Sequences the single shared main-memory port between I-cache miss fills, D-cache miss fills and D-cache write-through stores.
- Sits between the two cache miss paths and the multi-cycle pipelined main memory.
- Performs block refills word by word and generates the cache data-array and tag-array write strobes.
- Drives the busy indication that the pipeline uses to stall fetch and insert NOPs.

Parameters:
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of two, ≥2; block size = 2*WORDS_PER_BLOCK bytes.
- MEM_LATENCY, 4, cycles from a read issue (mem_en=1, mem_wr=0) to its mem_valid; ≥1.
- ADDR_W, 16, byte-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ic_miss  in  1  I-cache miss; level, held until ic_done.
- ic_miss_addr  in  ADDR_W  I-cache miss byte address.
- dc_miss  in  1  D-cache read miss; level, held until dc_done.
- dc_miss_addr  in  ADDR_W  D-cache miss byte address.
- dc_wr_req  in  1  D-cache write-through store; level, held until dc_wr_done.
- dc_wr_addr  in  ADDR_W  store address.
- dc_wr_data  in  16  store data.
- mem_en  out  1  memory request strobe.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_valid  in  1  read data valid.
- fill_data  out  16  refill word; equals mem_rdata.
- fill_word  out  log2(WORDS_PER_BLOCK)  word index within the block.
- ic_fill_we  out  1  I-cache data-array write.
- dc_fill_we  out  1  D-cache data-array write.
- ic_tag_we  out  1  I-cache tag/valid write.
- dc_tag_we  out  1  D-cache tag/valid write.
- ic_done  out  1  one-cycle pulse: I-cache fill complete.
- dc_done  out  1  one-cycle pulse: D-cache fill complete.
- dc_wr_done  out  1  one-cycle pulse: store issued.
- fsm_busy  out  1  arbiter not IDLE.

Behaviour:
- States: IDLE, WRITE, FILL, DONE. Owner register: ICACHE or DCACHE.
- Reset (rst=1 at a clock edge, any state including mid-fill):
  - State goes to IDLE; issue/recv counters, owner and latched base are cleared.
  - All outputs are 0 during and after reset.
  - mem_valid returning from a read issued before reset is ignored.
- IDLE arbitration, fixed priority dc_wr_req > dc_miss > ic_miss. The D-side wins because it is the older instruction in MEM.
  - dc_wr_req: go to WRITE.
  - Miss: latch base = miss_addr with the low log2(2*WORDS_PER_BLOCK) bits cleared; latch owner; clear both counters; go to FILL.
  - No outputs are driven in IDLE.
  - mem_valid is ignored in IDLE, WRITE and DONE.
- WRITE, exactly one cycle:
  - mem_en=1, mem_wr=1, mem_addr=dc_wr_addr, mem_wdata=dc_wr_data.
  - Next state IDLE; dc_wr_done pulses in that next cycle (registered).
  - A store wins again immediately if dc_wr_req is still high the cycle after dc_wr_done. The D-cache must drop it on dc_wr_done.
- FILL issue side:
  - While issue_cnt < WORDS_PER_BLOCK: mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt, issue_cnt++.
  - After the last issue, mem_en=0.
- FILL return side:
  - On mem_valid: fill_data=mem_rdata, fill_word=recv_cnt, and the owner's fill_we=1 (combinational, same cycle); recv_cnt++.
  - On mem_valid with recv_cnt == WORDS_PER_BLOCK-1, the owner's tag_we=1 in the same cycle, then next state DONE.
  - Counters saturate/wrap only through reset or a new grant. Address arithmetic is modulo 2^ADDR_W.
- DONE, exactly one cycle:
  - Owner's done pulses; new requests are ignored, so a still-asserted miss line cannot re-grant.
  - Next state IDLE.
- Latency: a miss sampled in IDLE at cycle T gives:
  - word k issued at T+1+k;
  - last fill_we and tag_we at T+WORDS_PER_BLOCK+MEM_LATENCY;
  - done at T+WORDS_PER_BLOCK+MEM_LATENCY+1.
  - Defaults: tag_we at T+12, done at T+13.
- Simultaneous ic_miss and dc_miss: D fill is served fully first, then I fill starts on the first IDLE cycle after dc_done. There is no preemption mid-fill.
- fsm_busy = (state != IDLE), registered.
- Exactly one of ic_fill_we/dc_fill_we can be high in any cycle. mem_wr=1 occurs only in WRITE.

Test Plan:
- Reset, then ic_miss=1 with ic_miss_addr=0x1236 at T → mem reads to 0x1230,0x1232,…,0x123E at T+1..T+8; ic_fill_we with fill_word 0..7 at T+5..T+12; ic_tag_we at T+12; ic_done at T+13; dc_* strobes stay 0.
- ic_miss and dc_miss (dc_miss_addr=0x4008) asserted the same cycle → D fill of 0x4000–0x400E completes first (dc_done); I fill begins the cycle after IDLE is re-entered.
- dc_wr_req=1 with dc_wr_addr=0x2002, dc_wr_data=0xBEEF while ic_miss=1 → one cycle of mem_en=1, mem_wr=1, addr 0x2002, data 0xBEEF; dc_wr_done next cycle; I fill follows.
- rst pulsed at T+6 during a fill → all outputs 0; stale mem_valid at T+7..T+9 produces no fill_we; a new miss afterwards is serviced normally from word 0.
- Miss held high through DONE → exactly one done pulse and no second fill issued; fsm_busy high T+1..T+13 and low at T+14.
- miss_addr=0xFFF2 → reads 0xFFF0..0xFFFE with no wrap into 0x0000; base computed correctly.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// Shared main-memory port between the cache miss arbiter and memory.
// Reads are pipelined with a fixed latency; writes complete on issue.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 16
) ();

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_valid;

  modport master (
    output mem_en,
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_valid
  );

  modport slave (
    input  mem_en,
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_valid
  );

endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the main-memory port between I/D refills and D stores.
// Refills are issued back to back; returns are written word by word.
module cache_mem_arbiter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4,
  parameter int ADDR_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ic_miss,
  input  logic [ADDR_W-1:0]                  ic_miss_addr,
  input  logic                               dc_miss,
  input  logic [ADDR_W-1:0]                  dc_miss_addr,
  input  logic                               dc_wr_req,
  input  logic [ADDR_W-1:0]                  dc_wr_addr,
  input  logic [15:0]                        dc_wr_data,
  cache_mem_arbiter_if.master                bus,
  output logic [15:0]                        fill_data,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic                               ic_fill_we,
  output logic                               dc_fill_we,
  output logic                               ic_tag_we,
  output logic                               dc_tag_we,
  output logic                               ic_done,
  output logic                               dc_done,
  output logic                               dc_wr_done,
  output logic                               fsm_busy
);

  localparam int WORD_W = $clog2(WORDS_PER_BLOCK);

  localparam logic [ADDR_W-1:0] BLK_MASK =
    ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  localparam logic [WORD_W:0] ISSUE_END =
    (WORD_W + 1)'(WORDS_PER_BLOCK);

  localparam logic [WORD_W-1:0] RECV_LAST =
    WORD_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FILL,
    DONE
  } state_t;

  typedef enum logic {
    ICACHE,
    DCACHE
  } owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [WORD_W:0]   issue_q, issue_d;
  logic [WORD_W-1:0] recv_q, recv_d;
  logic              wr_done_q;

  // One bit per in-flight read slot; a return is only accepted when
  // it matches a read issued since the last reset or grant.
  logic [MEM_LATENCY-1:0] rd_pipe_q;
  logic                   rd_issue;
  logic                   rd_ret;

  logic gnt_wr;
  logic gnt_dc;
  logic gnt_ic;

  logic              mem_en_c;
  logic              mem_wr_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [15:0]       mem_wdata_c;

  assign bus.mem_en    = mem_en_c;
  assign bus.mem_wr    = mem_wr_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;

  assign gnt_wr = dc_wr_req;
  assign gnt_dc = dc_miss & ~dc_wr_req;
  assign gnt_ic = ic_miss & ~dc_miss & ~dc_wr_req;

  assign rd_ret = bus.mem_valid & rd_pipe_q[MEM_LATENCY-1];

  assign dc_wr_done = wr_done_q & ~rst;
  assign fsm_busy   = (state_q != IDLE) & ~rst;

  // State, owner, block base, counters and read-tracking pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= ICACHE;
      base_q    <= '0;
      issue_q   <= '0;
      recv_q    <= '0;
      wr_done_q <= 1'b0;
      rd_pipe_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      base_q       <= base_d;
      issue_q      <= issue_d;
      recv_q       <= recv_d;
      wr_done_q    <= (state_q == WRITE);
      rd_pipe_q[0] <= rd_issue;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end
    end
  end

  // Next state, memory requests and cache write strobes.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    issue_d     = issue_q;
    recv_d      = recv_q;
    rd_issue    = 1'b0;
    mem_en_c    = 1'b0;
    mem_wr_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    fill_data   = '0;
    fill_word   = '0;
    ic_fill_we  = 1'b0;
    dc_fill_we  = 1'b0;
    ic_tag_we   = 1'b0;
    dc_tag_we   = 1'b0;
    ic_done     = 1'b0;
    dc_done     = 1'b0;

    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            gnt_wr: begin
              state_d = WRITE;
            end
            gnt_dc: begin
              state_d = FILL;
              owner_d = DCACHE;
              base_d  = dc_miss_addr & ~BLK_MASK;
              issue_d = '0;
              recv_d  = '0;
            end
            gnt_ic: begin
              state_d = FILL;
              owner_d = ICACHE;
              base_d  = ic_miss_addr & ~BLK_MASK;
              issue_d = '0;
              recv_d  = '0;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end

        WRITE: begin
          mem_en_c    = 1'b1;
          mem_wr_c    = 1'b1;
          mem_addr_c  = dc_wr_addr;
          mem_wdata_c = dc_wr_data;
          state_d     = IDLE;
        end

        FILL: begin
          if (issue_q < ISSUE_END) begin
            mem_en_c   = 1'b1;
            mem_addr_c = base_q + ADDR_W'({issue_q, 1'b0});
            issue_d    = issue_q + 1'b1;
            rd_issue   = 1'b1;
          end
          if (rd_ret) begin
            fill_data  = bus.mem_rdata;
            fill_word  = recv_q;
            ic_fill_we = (owner_q == ICACHE);
            dc_fill_we = (owner_q == DCACHE);
            recv_d     = recv_q + 1'b1;
            if (recv_q == RECV_LAST) begin
              ic_tag_we = (owner_q == ICACHE);
              dc_tag_we = (owner_q == DCACHE);
              state_d   = DONE;
            end
          end
        end

        DONE: begin
          ic_done = (owner_q == ICACHE);
          dc_done = (owner_q == DCACHE);
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized bench for cache_mem_arbiter against a transaction-level
// model that predicts every output from the grant cycle of each request.
module tb_cache_mem_arbiter;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int AW = 16;
  localparam int WW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ic_miss = 1'b0;
  logic [AW-1:0] ic_miss_addr = '0;
  logic          dc_miss = 1'b0;
  logic [AW-1:0] dc_miss_addr = '0;
  logic          dc_wr_req = 1'b0;
  logic [AW-1:0] dc_wr_addr = '0;
  logic [15:0]   dc_wr_data = '0;

  logic [15:0]   fill_data;
  logic [WW-1:0] fill_word;
  logic          ic_fill_we;
  logic          dc_fill_we;
  logic          ic_tag_we;
  logic          dc_tag_we;
  logic          ic_done;
  logic          dc_done;
  logic          dc_wr_done;
  logic          fsm_busy;

  int n_chk = 0;
  int n_err = 0;

  cache_mem_arbiter_if #(.ADDR_W(AW)) bus ();

  cache_mem_arbiter #(
    .WORDS_PER_BLOCK(W),
    .MEM_LATENCY(L),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ic_miss(ic_miss),
    .ic_miss_addr(ic_miss_addr),
    .dc_miss(dc_miss),
    .dc_miss_addr(dc_miss_addr),
    .dc_wr_req(dc_wr_req),
    .dc_wr_addr(dc_wr_addr),
    .dc_wr_data(dc_wr_data),
    .bus(bus),
    .fill_data(fill_data),
    .fill_word(fill_word),
    .ic_fill_we(ic_fill_we),
    .dc_fill_we(dc_fill_we),
    .ic_tag_we(ic_tag_we),
    .dc_tag_we(dc_tag_we),
    .ic_done(ic_done),
    .dc_done(dc_done),
    .dc_wr_done(dc_wr_done),
    .fsm_busy(fsm_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memfn(input logic [15:0] a);
    return (a * 16'd40503) ^ 16'h5A5A;
  endfunction

  // Fixed-latency memory; keeps its pipeline across DUT resets.
  bit          pv [L];
  bit [15:0]   pa [L];

  always @(posedge clk) begin
    pv[0] <= bus.mem_en && !bus.mem_wr;
    pa[0] <= bus.mem_addr;
    for (int i = 1; i < L; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end

  assign bus.mem_valid = pv[L-1];
  assign bus.mem_rdata = memfn(pa[L-1]);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  // Model: kind -1 none, 0 I fill, 1 D fill, 2 store.
  int          cyc = 0;
  int          kind = -1;
  int          g = 0;
  int          free_at = 0;
  logic [15:0] mbase = '0;
  logic [15:0] w_addr = '0;
  logic [15:0] w_data = '0;

  task automatic step(input bit r,
                      input bit ric, input logic [15:0] aic,
                      input bit rdc, input logic [15:0] adc,
                      input bit rwr, input logic [15:0] awr,
                      input logic [15:0] dwr);
    int d;
    int word;
    logic e_en, e_wr, e_icwe, e_dcwe, e_ictag, e_dctag;
    logic e_icdone, e_dcdone, e_wrdone, e_busy;
    logic [15:0] e_addr, e_wdata, e_fdata;
    int e_fword;

    @(posedge clk);
    #1;
    rst = r;
    if (ric && !ic_miss) begin
      ic_miss = 1'b1;
      ic_miss_addr = aic;
    end
    if (rdc && !dc_miss) begin
      dc_miss = 1'b1;
      dc_miss_addr = adc;
    end
    if (rwr && !dc_wr_req) begin
      dc_wr_req = 1'b1;
      dc_wr_addr = awr;
      dc_wr_data = dwr;
    end

    @(negedge clk);
    {e_en, e_wr, e_icwe, e_dcwe, e_ictag, e_dctag} = '0;
    {e_icdone, e_dcdone, e_wrdone, e_busy} = '0;
    e_addr = '0;
    e_wdata = '0;
    e_fdata = '0;
    e_fword = 0;

    if (r) begin
      kind = -1;
      free_at = cyc + 1;
    end else if (kind == 2) begin
      d = cyc - g;
      if (d == 1) begin
        e_en = 1'b1;
        e_wr = 1'b1;
        e_addr = w_addr;
        e_wdata = w_data;
        e_busy = 1'b1;
      end
      if (d == 2) e_wrdone = 1'b1;
    end else if (kind >= 0) begin
      d = cyc - g;
      e_busy = (d >= 1) && (d <= W + L + 1);
      if (d >= 1 && d <= W) begin
        e_en = 1'b1;
        e_addr = mbase + 16'(2 * (d - 1));
      end
      if (d >= L + 1 && d <= W + L) begin
        word = d - L - 1;
        e_fdata = memfn(mbase + 16'(2 * word));
        e_fword = word;
        if (kind == 0) e_icwe = 1'b1;
        else e_dcwe = 1'b1;
      end
      if (d == W + L) begin
        if (kind == 0) e_ictag = 1'b1;
        else e_dctag = 1'b1;
      end
      if (d == W + L + 1) begin
        if (kind == 0) e_icdone = 1'b1;
        else e_dcdone = 1'b1;
      end
    end

    chk("strobes",
        {bus.mem_en, bus.mem_wr, ic_fill_we, dc_fill_we, ic_tag_we,
         dc_tag_we, ic_done, dc_done, dc_wr_done, fsm_busy},
        {e_en, e_wr, e_icwe, e_dcwe, e_ictag, e_dctag,
         e_icdone, e_dcdone, e_wrdone, e_busy});
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_wdata", bus.mem_wdata, e_wdata);
    chk("fill_data", fill_data, e_fdata);
    chk("fill_word", fill_word, e_fword);

    if (e_icdone) ic_miss = 1'b0;
    if (e_dcdone) dc_miss = 1'b0;
    if (e_wrdone) dc_wr_req = 1'b0;

    if (!r && cyc >= free_at) begin
      if (dc_wr_req) begin
        kind = 2;
        g = cyc;
        free_at = cyc + 2;
        w_addr = dc_wr_addr;
        w_data = dc_wr_data;
      end else if (dc_miss) begin
        kind = 1;
        g = cyc;
        free_at = cyc + W + L + 2;
        mbase = dc_miss_addr - 16'(dc_miss_addr % (2 * W));
      end else if (ic_miss) begin
        kind = 0;
        g = cyc;
        free_at = cyc + W + L + 2;
        mbase = ic_miss_addr - 16'(ic_miss_addr % (2 * W));
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);

    step(1'b0, 1'b1, 16'h1236, 1'b0, '0, 1'b0, '0, '0);
    idle(16);

    step(1'b0, 1'b1, 16'h0104, 1'b1, 16'h4008, 1'b0, '0, '0);
    idle(36);

    step(1'b0, 1'b1, 16'h0200, 1'b0, '0, 1'b1, 16'h2002, 16'hBEEF);
    idle(20);

    step(1'b0, 1'b1, 16'h0316, 1'b0, '0, 1'b0, '0, '0);
    idle(5);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    idle(18);

    step(1'b0, 1'b1, 16'hFFF2, 1'b0, '0, 1'b0, '0, '0);
    idle(16);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(199) == 0,
           $urandom_range(3) == 0, 16'($urandom),
           $urandom_range(3) == 0, 16'($urandom),
           $urandom_range(5) == 0, 16'($urandom), 16'($urandom));
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
